alu_issue_stage: RTL

//  Upstream issue/operand stage for the 16-bit combinational ALU (fs: 0 ADD, 1 SHL, 2 SHR, 3 NAND).
//  - Accepts commands over a valid/ready handshake and reads operands from a small register file.
//  - Registers fs/a/b into the ALU, captures the ALU result one cycle later and writes it back.
//  - Presents each writeback on a valid/ready output for a downstream trace/consumer.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_regfile.sv | 48 ++++
 rtl/alu_issue_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage: command opcodes, ALU function
// selects, default widths and a helper that classifies opcodes.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DW    = 16;
  localparam int NREGS = 4;
  localparam int RW    = $clog2(NREGS);

  // Command opcodes presented on cmd_op; both 6 and 7 are NOPs.
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_NAND = 3'd3,
    OP_LDI  = 3'd4,
    OP_ADDI = 3'd5,
    OP_NOP  = 3'd6,
    OP_NOP7 = 3'd7
  } op_e;

  // Function selects understood by the downstream ALU.
  typedef enum logic [1:0] {
    FS_ADD  = 2'd0,
    FS_SHL  = 2'd1,
    FS_SHR  = 2'd2,
    FS_NAND = 2'd3
  } fs_e;

  // True for every opcode that produces a register write and a wb pulse.
  function automatic logic op_writes(input logic [2:0] op);
    logic res;
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: res = 1'b1;
      default:                             res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// NREGS x DW register file: two asynchronous read ports for operand fetch,
// one asynchronous debug read port and a single synchronous write port.
// Synchronous active-high reset clears every entry.
// Ports:
//   clk, i_rst              clock / synchronous reset
//   i_we, i_waddr, i_wdata  write port
//   i_raddr_a / o_rdata_a   operand A read
//   i_raddr_b / o_rdata_b   operand B read
//   i_dbg_sel / o_dbg_data  debug read
// -----------------------------------------------------------------------------
module alu_regfile #(
  parameter int DW    = 16,
  parameter int NREGS = 4,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [RW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [RW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [RW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b,
  input  logic [RW-1:0] i_dbg_sel,
  output logic [DW-1:0] o_dbg_data
);

  logic [DW-1:0] r_mem [NREGS];

  // Storage: clear on reset, otherwise at most one write per cycle.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= {DW{1'b0}};
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_sel];

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Issue/operand stage feeding an external 16-bit combinational ALU.
// Commands arrive on a valid/ready handshake, operands come from a small
// register file (with forwarding from the result currently in E), and each
// result is written back and announced on a valid/ready writeback port.
//
// Pipeline:  E (e_valid/e_op/e_dst, drives alu_fs/a/b)  ->  W (wb_valid/dst/data)
//
// Ports:
//   clk, rst                       clock / synchronous active-high reset
//   cmd_valid/ready, cmd_op/dst/   command handshake and fields
//     srca/srcb/imm
//   alu_fs/a/b (out), alu_c (in)   registered ALU operands, ALU result
//   wb_valid/ready, wb_dst/data    writeback notification handshake
//   dbg_sel / dbg_data             combinational register-file peek
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int DW    = 16,
  parameter int NREGS = 4,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [RW-1:0] cmd_dst,
  input  logic [RW-1:0] cmd_srca,
  input  logic [RW-1:0] cmd_srcb,
  input  logic [DW-1:0] cmd_imm,
  output logic [1:0]    alu_fs,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_c,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [RW-1:0] wb_dst,
  output logic [DW-1:0] wb_data,
  input  logic [RW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data
);

  import alu_pkg::*;

  // E stage
  logic          r_e_valid;
  logic [2:0]    r_e_op;
  logic [RW-1:0] r_e_dst;
  logic [1:0]    r_alu_fs;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;

  // W stage
  logic          r_wb_valid;
  logic [RW-1:0] r_wb_dst;
  logic [DW-1:0] r_wb_data;

  // Control
  logic          w_stall;
  logic          w_e_advance;
  logic          w_cmd_ready;
  logic          w_accept;
  logic          w_e_writes;
  logic          w_rf_we;

  // Operand path
  logic [DW-1:0] w_rf_a;
  logic [DW-1:0] w_rf_b;
  logic [DW-1:0] w_opnd_a;
  logic [DW-1:0] w_opnd_b;
  logic [1:0]    w_nxt_fs;
  logic [DW-1:0] w_nxt_a;
  logic [DW-1:0] w_nxt_b;

  assign w_stall     = r_wb_valid & ~wb_ready;
  assign w_e_advance = r_e_valid & ~w_stall;
  assign w_cmd_ready = ~r_e_valid | ~w_stall;
  assign w_accept    = cmd_valid & w_cmd_ready;

  // E only writes back when it holds a non-NOP op; the write lands on the
  // same edge that E advances.
  assign w_e_writes  = r_e_valid & op_writes(r_e_op);
  assign w_rf_we     = w_e_advance & op_writes(r_e_op);

  alu_regfile #(
    .DW    (DW),
    .NREGS (NREGS)
  ) u_regfile (
    .clk        (clk),
    .i_rst      (rst),
    .i_we       (w_rf_we),
    .i_waddr    (r_e_dst),
    .i_wdata    (alu_c),
    .i_raddr_a  (cmd_srca),
    .o_rdata_a  (w_rf_a),
    .i_raddr_b  (cmd_srcb),
    .o_rdata_b  (w_rf_b),
    .i_dbg_sel  (dbg_sel),
    .o_dbg_data (dbg_data)
  );

  // Forwarding: an accept while E is valid implies E advances on the same
  // edge, so the E result is exactly what R[e_dst] is about to become.
  assign w_opnd_a = (w_e_writes && (r_e_dst == cmd_srca)) ? alu_c : w_rf_a;
  assign w_opnd_b = (w_e_writes && (r_e_dst == cmd_srcb)) ? alu_c : w_rf_b;

  // Map the incoming command onto ALU function select and operands.
  always_comb begin
    w_nxt_fs = FS_ADD;
    w_nxt_a  = {DW{1'b0}};
    w_nxt_b  = {DW{1'b0}};
    case (op_e'(cmd_op))
      OP_ADD, OP_SHL, OP_SHR, OP_NAND: begin
        w_nxt_fs = cmd_op[1:0];
        w_nxt_a  = w_opnd_a;
        w_nxt_b  = w_opnd_b;
      end
      OP_LDI: begin
        w_nxt_fs = FS_ADD;
        w_nxt_a  = cmd_imm;
        w_nxt_b  = {DW{1'b0}};
      end
      OP_ADDI: begin
        w_nxt_fs = FS_ADD;
        w_nxt_a  = w_opnd_a;
        w_nxt_b  = cmd_imm;
      end
      OP_NOP, OP_NOP7: begin
        w_nxt_fs = FS_ADD;
        w_nxt_a  = {DW{1'b0}};
        w_nxt_b  = {DW{1'b0}};
      end
      default: begin
        w_nxt_fs = FS_ADD;
        w_nxt_a  = {DW{1'b0}};
        w_nxt_b  = {DW{1'b0}};
      end
    endcase
  end

  // E stage: load on accept, drain on advance, otherwise hold (ALU inputs
  // stay steady while stalled).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_valid <= 1'b0;
      r_e_op    <= 3'd0;
      r_e_dst   <= {RW{1'b0}};
      r_alu_fs  <= 2'd0;
      r_alu_a   <= {DW{1'b0}};
      r_alu_b   <= {DW{1'b0}};
    end else if (w_accept) begin
      r_e_valid <= 1'b1;
      r_e_op    <= cmd_op;
      r_e_dst   <= cmd_dst;
      r_alu_fs  <= w_nxt_fs;
      r_alu_a   <= w_nxt_a;
      r_alu_b   <= w_nxt_b;
    end else if (w_e_advance) begin
      r_e_valid <= 1'b0;
    end
  end

  // W stage: a new result takes priority over clearing, so back-to-back
  // results stream without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_dst   <= {RW{1'b0}};
      r_wb_data  <= {DW{1'b0}};
    end else if (w_rf_we) begin
      r_wb_valid <= 1'b1;
      r_wb_dst   <= r_e_dst;
      r_wb_data  <= alu_c;
    end else if (r_wb_valid && wb_ready) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign alu_fs    = r_alu_fs;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign wb_valid  = r_wb_valid;
  assign wb_dst    = r_wb_dst;
  assign wb_data   = r_wb_data;

endmodule
